// File: rtl/csi_rx_pkg.sv
// Shared definitions for the CSI-2 receiver: link-training state encoding and default timing.
package csi_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_DWELL,
        ST_EVAL,
        ST_CENTER,
        ST_RUN,
        ST_FAIL
    } train_state_t;

    localparam int TAP_W_DEF   = 5;
    localparam int SETTLE_DEF  = 16;
    localparam int DWELL_DEF   = 4096;
    localparam int MIN_EYE_DEF = 3;
    localparam int ERR_MAX_DEF = 8;

endpackage

// File: rtl/csi_rx_eye_track.sv
// Tracks contiguous runs of good IDELAY taps during a sweep and reports the centre of the widest eye.
module csi_rx_eye_track
    import csi_rx_pkg::*;
#(
    parameter int TAP_W = TAP_W_DEF
)(
    input  logic             byte_clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             eval,
    input  logic             hit,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W:0]   best_len,
    output logic [TAP_W-1:0] centre_tap
);

    logic [TAP_W:0]   run_len;
    logic [TAP_W:0]   run_len_nxt;
    logic [TAP_W-1:0] run_start;
    logic [TAP_W-1:0] run_start_nxt;
    logic [TAP_W-1:0] best_start;

    function automatic logic [TAP_W-1:0] eye_centre(input logic [TAP_W-1:0] start,
                                                    input logic [TAP_W:0]   len);
        return TAP_W'({1'b0, start} + (len >> 1));
    endfunction

    always_comb begin
        run_len_nxt   = hit ? run_len + 1'b1 : '0;
        run_start_nxt = (hit && run_len == '0) ? tap : run_start;
    end

    // Best window follows the growing run, so a run still open at the last tap is already counted.
    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
        end else if (clear) begin
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
        end else if (eval) begin
            run_len   <= run_len_nxt;
            run_start <= run_start_nxt;
            if (run_len_nxt > best_len) begin
                best_len   <= run_len_nxt;
                best_start <= run_start_nxt;
            end
        end
    end

    assign centre_tap = eye_centre(best_start, best_len);

endmodule

// File: rtl/csi_rx_link_train.sv
// D-PHY lane deskew trainer: sweeps IDELAY taps per lane, centres each lane in its widest eye,
// then monitors packet errors and retrains when they accumulate.
module csi_rx_link_train
    import csi_rx_pkg::*;
#(
    parameter int NLANES  = 2,
    parameter int TAP_W   = TAP_W_DEF,
    parameter int SETTLE  = SETTLE_DEF,
    parameter int DWELL   = DWELL_DEF,
    parameter int MIN_EYE = MIN_EYE_DEF,
    parameter int ERR_MAX = ERR_MAX_DEF
)(
    input  logic                    byte_clock,
    input  logic                    reset_n,
    input  logic                    clk_det_reset,
    input  logic [NLANES-1:0]       sync_ok,
    input  logic                    err_pulse,
    input  logic                    retrain,
    output logic                    lane_en,
    output logic [NLANES-1:0]       dly_ld,
    output logic [NLANES*TAP_W-1:0] dly_tap,
    output logic                    link_up,
    output logic                    link_fail
);

    localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int CNT_W  = $clog2(((SETTLE > DWELL) ? SETTLE : DWELL) + 1);
    localparam int ERR_W  = $clog2(ERR_MAX + 1);

    train_state_t      state;
    logic [LANE_W-1:0] lane;
    logic [TAP_W-1:0]  tap;
    logic [CNT_W-1:0]  cnt;
    logic [ERR_W-1:0]  err_cnt;
    logic              hit;
    logic [1:0]        reset_in_demet;
    logic              trk_clear;
    logic              trk_eval;
    logic [TAP_W:0]    best_len;
    logic [TAP_W-1:0]  centre_tap;

    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_W'(ERR_MAX)) ? v : v + 1'b1;
    endfunction

    // Reset asserts asynchronously but only releases the FSM on a byte_clock edge.
    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) reset_in_demet <= 2'b00;
        else          reset_in_demet <= {reset_in_demet[0], 1'b1};
    end

    assign trk_eval  = (state == ST_EVAL);
    assign trk_clear = clk_det_reset | retrain |
                       (state inside {ST_IDLE, ST_CENTER, ST_RUN, ST_FAIL});

    csi_rx_eye_track #(.TAP_W(TAP_W)) u_eye_track (
        .byte_clock (byte_clock),
        .reset_n    (reset_n),
        .clear      (trk_clear),
        .eval       (trk_eval),
        .hit        (hit),
        .tap        (tap),
        .best_len   (best_len),
        .centre_tap (centre_tap)
    );

    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            lane      <= '0;
            tap       <= '0;
            cnt       <= '0;
            err_cnt   <= '0;
            hit       <= 1'b0;
            dly_ld    <= '0;
            dly_tap   <= '0;
            lane_en   <= 1'b0;
            link_up   <= 1'b0;
            link_fail <= 1'b0;
        end else begin
            dly_ld <= '0;
            if (clk_det_reset) begin
                state     <= ST_IDLE;
                cnt       <= '0;
                err_cnt   <= '0;
                lane_en   <= 1'b0;
                link_up   <= 1'b0;
                link_fail <= 1'b0;
            end else if (retrain && state != ST_IDLE) begin
                state     <= ST_LOAD;
                lane      <= '0;
                tap       <= '0;
                cnt       <= '0;
                err_cnt   <= '0;
                lane_en   <= 1'b1;
                link_up   <= 1'b0;
                link_fail <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (reset_in_demet[1]) begin
                            state   <= ST_LOAD;
                            lane    <= '0;
                            tap     <= '0;
                            lane_en <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        dly_tap[lane*TAP_W +: TAP_W] <= tap;
                        dly_ld[lane]                 <= 1'b1;
                        cnt                          <= '0;
                        state                        <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (cnt == CNT_W'(SETTLE - 1)) begin
                            cnt   <= '0;
                            hit   <= 1'b0;
                            state <= ST_DWELL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_DWELL: begin
                        if (sync_ok[lane]) hit <= 1'b1;
                        if (cnt == CNT_W'(DWELL - 1)) begin
                            cnt   <= '0;
                            state <= ST_EVAL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_EVAL: begin
                        if (tap == '1) begin
                            state <= ST_CENTER;
                        end else begin
                            tap   <= tap + 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                    ST_CENTER: begin
                        if (best_len < (TAP_W+1)'(MIN_EYE)) begin
                            link_fail <= 1'b1;
                            state     <= ST_FAIL;
                        end else begin
                            dly_tap[lane*TAP_W +: TAP_W] <= centre_tap;
                            dly_ld[lane]                 <= 1'b1;
                            if (lane == LANE_W'(NLANES - 1)) begin
                                err_cnt <= '0;
                                link_up <= 1'b1;
                                state   <= ST_RUN;
                            end else begin
                                lane  <= lane + 1'b1;
                                tap   <= '0;
                                state <= ST_LOAD;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (err_pulse) begin
                            if (err_sat_inc(err_cnt) == ERR_W'(ERR_MAX)) begin
                                err_cnt <= '0;
                                lane    <= '0;
                                tap     <= '0;
                                link_up <= 1'b0;
                                state   <= ST_LOAD;
                            end else begin
                                err_cnt <= err_sat_inc(err_cnt);
                            end
                        end
                    end
                    ST_FAIL: begin
                        state <= ST_FAIL;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
